// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  localparam int unsigned NREQ = 2;
  localparam int unsigned ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Round-robin pick between two requesters: a lone request wins,
  // a tie goes to the requester that was not served last.
  function automatic logic pick_winner(input logic [NREQ-1:0] req, input logic last_id);
    logic w;
    if (req[0] && req[1]) w = ~last_id;
    else                  w = req[1];
    return w;
  endfunction

endpackage

// File: rtl/full_adder_1b.sv
// Combinational 1-bit full adder.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_arbiter.sv
// Bit-serial adder shared by two requesters through a round-robin arbiter.
// One full adder is stepped LSB to MSB with a registered carry.
module serial_add_arbiter
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin0,
  input  logic             cin1,
  output logic [NREQ-1:0]  gnt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             last_id;
  logic [CNT_W-1:0] bit_cnt;

  logic             fa_sum;
  logic             fa_cout;
  logic [NREQ-1:0]  req;
  logic             winner;
  logic [WIDTH:0]   res_ext;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  full_adder_1b u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Request vector, arbitration winner and next result word
  always_comb begin
    req      = {req1, req0};
    winner   = pick_winner(req, last_id);
    // Extending by the new sum bit and dropping the LSB keeps the shift legal for WIDTH=1
    res_ext  = {fa_sum, res};
    res_next = res_ext[WIDTH:1];
    last_bit = (bit_cnt == CNT_W'(WIDTH - 1));
  end

  // Sequencer: arbitrate in IDLE, step one bit per clock in ADD, pulse done in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      last_id <= 1'b1;
      a_sh    <= '0;
      b_sh    <= '0;
      res     <= '0;
      carry   <= 1'b0;
      bit_cnt <= '0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req != '0) begin
            gnt     <= winner ? 2'b10 : 2'b01;
            busy    <= 1'b1;
            last_id <= winner;
            a_sh    <= winner ? a1 : a0;
            b_sh    <= winner ? b1 : b0;
            carry   <= winner ? cin1 : cin0;
            res     <= '0;
            bit_cnt <= '0;
            state   <= ADD;
          end
        end
        ADD: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          carry   <= fa_cout;
          res     <= res_next;
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (last_bit) begin
            sum     <= res_next;
            cout    <= fa_cout;
            done_id <= last_id;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed self-checking bench for serial_add_arbiter (WIDTH=8 and WIDTH=1 instances).
module tb_serial_add_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       cin0 = 1'b0, cin1 = 1'b0;
  logic [1:0] gnt;
  logic       busy, done, done_id, cout;
  logic [7:0] sum;

  logic       w_req0 = 1'b0, w_req1 = 1'b0;
  logic [0:0] w_a0 = '0, w_b0 = '0, w_a1 = '0, w_b1 = '0;
  logic       w_cin0 = 1'b0, w_cin1 = 1'b0;
  logic [1:0] w_gnt;
  logic       w_busy, w_done, w_done_id, w_cout;
  logic [0:0] w_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .cin0(cin0), .cin1(cin1),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .sum(sum), .cout(cout)
  );

  serial_add_arbiter #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst(rst), .req0(w_req0), .req1(w_req1),
    .a0(w_a0), .b0(w_b0), .a1(w_a1), .b1(w_b1), .cin0(w_cin0), .cin1(w_cin1),
    .gnt(w_gnt), .busy(w_busy), .done(w_done), .done_id(w_done_id), .sum(w_sum), .cout(w_cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 transaction from a single requester, checked end to end.
  task automatic add8(input logic id, input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] es, input logic ec, input string tag);
    int n;
    @(negedge clk);
    if (id) begin a1 = a; b1 = b; cin1 = c; req1 = 1'b1; end
    else    begin a0 = a; b0 = b; cin0 = c; req0 = 1'b1; end
    n = 0;
    do begin @(negedge clk); n++; end while (gnt === 2'b00 && n < 30);
    check({tag, "_gnt"}, 32'(gnt), id ? 32'h2 : 32'h1);
    check({tag, "_busy_up"}, 32'(busy), 32'h1);
    req0 = 1'b0; req1 = 1'b0;
    a0 = '1; b0 = '1; a1 = '1; b1 = '1;
    n = 0;
    while (done !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    check({tag, "_latency"}, 32'(n), 32'd8);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_done_id"}, 32'(done_id), 32'(id));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'h0);
    check({tag, "_busy_down"}, 32'(busy), 32'h0);
  endtask

  // One WIDTH=1 transaction; done must follow the grant by one cycle.
  task automatic add1(input logic a, input logic b, input logic c);
    int n;
    logic [1:0] exp;
    exp = 2'(a) + 2'(b) + 2'(c);
    @(negedge clk);
    w_a0 = a; w_b0 = b; w_cin0 = c; w_req0 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (w_gnt === 2'b00 && n < 30);
    check("w1_gnt", 32'(w_gnt), 32'h1);
    w_req0 = 1'b0;
    @(negedge clk);
    check("w1_done", 32'(w_done), 32'h1);
    check("w1_result", 32'({w_cout, w_sum}), 32'(exp));
    @(negedge clk);
  endtask

  initial begin
    int cyc, ng, nd, last_g;
    logic saw;

    // Asynchronous reset between edges
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_done_id", 32'(done_id), 32'h0);
    check("rst_sum", 32'(sum), 32'h0);
    check("rst_cout", 32'(cout), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (gnt !== 2'b00 || busy !== 1'b0) saw = 1'b1;
    end
    check("idle_no_gnt", 32'(saw), 32'h0);

    // Single adds and carry corner cases
    add8(1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "add_0f_01");
    add8(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
    add8(1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "add_ff_ff_c");
    add8(1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "add_00_00_c");
    add8(1'b1, 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, "add_r1_a5_5a");

    // Fairness: reset restores last_id=1 so requester 0 wins the first tie
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a0 = 8'h12; b0 = 8'h34; cin0 = 1'b0;
    a1 = 8'hF0; b1 = 8'h20; cin1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    cyc = 0; ng = 0; nd = 0; last_g = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      cyc++;
      if (gnt !== 2'b00) begin
        check("fair_gnt", 32'(gnt), (ng % 2 == 0) ? 32'h1 : 32'h2);
        if (ng > 0) check("fair_spacing", 32'(cyc - last_g), 32'd10);
        last_g = cyc;
        ng++;
        if (ng == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
      if (done === 1'b1) begin
        check("fair_done_id", 32'(done_id), 32'(nd % 2));
        if (nd % 2 == 0) check("fair_res0", 32'({cout, sum}), 32'h046);
        else             check("fair_res1", 32'({cout, sum}), 32'h111);
        nd++;
      end
    end
    check("fair_ngrants", 32'(ng), 32'd4);
    check("fair_ndone", 32'(nd), 32'd4);

    // Reset in the 4th ADD cycle aborts the add
    @(negedge clk);
    a0 = 8'h33; b0 = 8'h44; cin0 = 1'b0; req0 = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (gnt === 2'b00 && cyc < 30);
    check("mid_gnt", 32'(gnt), 32'h1);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_pre", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("mid_busy", 32'(busy), 32'h0);
    check("mid_sum", 32'(sum), 32'h0);
    check("mid_cout", 32'(cout), 32'h0);
    check("mid_done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done !== 1'b0) saw = 1'b1;
    end
    check("mid_no_done", 32'(saw), 32'h0);
    add8(1'b1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "post_rst_r1");

    // WIDTH=1 exhaustive
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      vv = 3'(v);
      add1(vv[2], vv[1], vv[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
